// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst controller: default widths,
// FSM state encoding, the read-beat record and the read FIFO sizing rule.
package ram_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // One returned read beat as it sits in the output FIFO.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } rd_beat_t;

    // Enough room for every read that can be in the RAM pipe plus
    // two beats of slack so a consumer at full rate never starves issue.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding returned read beats {data, last}.
// Head is shown combinationally; push/pop are ignored when full/empty.
module ram_rd_fifo
    import ram_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = DEF_DATA_W + 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status and head are decoded from the registered count/pointers.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst access controller in front of a single-port synchronous RAM.
// Optional macro RAM_BURST_CTRL_BOUNDARY_ERR_EN: adds cmd_err and rejects
// bursts that would run past the top address instead of wrapping to 0.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_WRITE | accepting write beats, one RAM write per wr handshake
// ST_READ  | issuing reads while FIFO credits are available
// ST_DRAIN | all reads issued, waiting for pipe and FIFO to empty
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    ,
    output logic              cmd_err
`endif
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W      = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [LEN_W-1:0]  remaining;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_last;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W:0]   fifo_head;
    logic              cmd_fire;
    logic              cmd_reject;
    logic              wr_fire;
    logic              rd_issue;
    logic              rd_pop;

    // Bursts whose last beat would pass the top address.
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    assign cmd_reject = (SUM_W'(cmd_addr) + SUM_W'(cmd_len)) > SUM_W'({ADDR_W{1'b1}});
`else
    assign cmd_reject = 1'b0;
`endif

    // Number of reads currently travelling through the RAM latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_valid[i]);
        end
    end

    // Next-state logic plus handshakes and RAM port drive.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b1;
        cmd_fire  = 1'b0;
        wr_fire   = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                cmd_fire  = cmd_valid;
                if (cmd_fire && !cmd_reject) begin
                    state_nxt = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_ready = 1'b1;
                wr_fire  = wr_valid;
                if (wr_fire && (remaining == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                // Credit check: every issued read must already own a FIFO slot.
                rd_issue = ((CNT_W + 1)'(inflight) + (CNT_W + 1)'(fifo_count)
                            < (CNT_W + 1)'(FIFO_DEPTH)) && !fifo_full;
                if (rd_issue && (remaining == '0)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((inflight == '0) && fifo_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        ram_we    = wr_fire;
        ram_addr  = (wr_fire || rd_issue) ? cur_addr : addr_hold;
        ram_wdata = wr_fire ? wr_data : wdata_hold;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst address/length tracking and the held RAM port values between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr   <= '0;
            remaining  <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            if (cmd_fire && !cmd_reject) begin
                cur_addr  <= cmd_addr;
                remaining <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                addr_hold <= cur_addr;
                if (remaining != '0) begin
                    remaining <= remaining - LEN_W'(1);
                end
            end
            if (wr_fire) begin
                wdata_hold <= wr_data;
            end
        end
    end

    // Read latency pipe carrying valid and last alongside the RAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
        end else begin
            pipe_valid[0] <= rd_issue;
            pipe_last[0]  <= rd_issue && (remaining == '0);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end
        end
    end

`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    // One-cycle error pulse following a rejected command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_fire && cmd_reject;
        end
    end
`endif

    assign rd_pop   = !fifo_empty && rd_ready;
    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_head[DATA_W:1];
    assign rd_last  = fifo_head[0] && !fifo_empty;

    ram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid[RD_LAT-1]),
        .push_data ({ram_rdata, pipe_last[RD_LAT-1]}),
        .pop       (rd_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural 1K x 8 RAM, reference memory image,
// directed scenarios followed by randomized write/read bursts.
`timescale 1ns/1ps
module tb_ram_burst_ctrl;

    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int TMO        = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready, rd_last, busy, ram_we;
    logic [7:0] rd_data, ram_wdata, ram_rdata;
    logic [9:0] ram_addr;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
    logic       cmd_err;
`endif

    ram_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
        , .cmd_err(cmd_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM, one clock read latency, cleared on its first clock.
    logic [7:0] ram_mem [1024];
    logic [7:0] ram_q;
    bit         ram_inited = 1'b0;
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= 8'h00;
            ram_inited <= 1'b1;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_q <= ram_mem[ram_addr];
    end
    assign ram_rdata = ram_q;

    // Reference image of what the RAM must hold.
    logic [7:0] ref_mem [1024];
    logic [7:0] wbuf [256];

    int n_assert = 0;
    int n_fail   = 0;

    // Observation state filled by the monitor.
    logic [17:0] wr_log [$];
    logic [8:0]  rd_q [$];
    bit          rd_track;
    int          iss_cnt, iss_target, pop_cnt, first_iss_cyc, first_rdv_cyc;
    int          credit_bad, we_bad, last_we_cyc, cmdrdy_rise_cyc;
    int          err_cycles, busy_cycles, wrrdy_cycles;
    logic [9:0]  iss_next;
    bit          cmd_ready_prev = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                wr_log.push_back({ram_addr, ram_wdata});
                last_we_cyc = cyc;
            end
            if (ram_we !== (wr_valid && wr_ready)) we_bad++;
            if (rd_track && busy && !ram_we && iss_cnt < iss_target && ram_addr == iss_next) begin
                if (iss_cnt == 0) first_iss_cyc = cyc;
                iss_cnt++;
                iss_next = iss_next + 10'd1;
            end
            if (iss_cnt - pop_cnt > FIFO_DEPTH) credit_bad++;
            if (rd_valid && first_rdv_cyc < 0) first_rdv_cyc = cyc;
            if (rd_valid && rd_ready) begin
                rd_q.push_back({rd_last, rd_data});
                pop_cnt++;
            end
            if (cmd_ready && !cmd_ready_prev) cmdrdy_rise_cyc = cyc;
            cmd_ready_prev = cmd_ready;
            if (busy) busy_cycles++;
            if (wr_ready) wrrdy_cycles++;
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
            if (cmd_err) err_cycles++;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        wr_log.delete();
        rd_q.delete();
        rd_track = 1'b0;
        iss_cnt = 0; iss_target = 0; pop_cnt = 0;
        first_iss_cyc = -1; first_rdv_cyc = -1;
        credit_bad = 0; we_bad = 0; last_we_cyc = -1; cmdrdy_rise_cyc = -1;
        err_cycles = 0; busy_cycles = 0; wrrdy_cycles = 0;
    endtask

    task automatic do_cmd(input bit wr, input logic [9:0] addr, input int len);
        int k = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
        while (!cmd_ready && k < TMO) begin @(posedge clk); #1; k++; end
        if (k >= TMO) chk("cmd_ready_timeout", 1, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < TMO) begin @(posedge clk); #1; k++; end
        if (k >= TMO) chk(tag, 1, 0);
    endtask

    task automatic do_write(input logic [9:0] addr, input int len, input bit gap);
        int k;
        clear_trk();
        do_cmd(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            wr_valid = 1'b1; wr_data = wbuf[i];
            k = 0;
            while (!wr_ready && k < 50) begin @(posedge clk); #1; k++; end
            if (k >= 50) begin chk("wr_ready_timeout", 1, 0); break; end
            @(posedge clk); #1;
            wr_valid = 1'b0;
            if (gap) begin @(posedge clk); #1; end
        end
        wr_valid = 1'b0;
        wait_idle("write_idle_timeout");
        for (int i = 0; i <= len; i++) ref_mem[(int'(addr) + i) % 1024] = wbuf[i];
    endtask

    task automatic check_write(input logic [9:0] addr, input int len);
        chk("wr_beats", wr_log.size(), len + 1);
        for (int i = 0; i <= len && i < wr_log.size(); i++) begin
            chk("wr_addr", {22'd0, wr_log[i][17:8]}, (int'(addr) + i) % 1024);
            chk("wr_data", {24'd0, wr_log[i][7:0]}, {24'd0, wbuf[i]});
        end
        chk("we_only_on_handshake", we_bad, 0);
    endtask

    // pat 0: rd_ready always high; pat 1: high one cycle in three.
    task automatic do_read(input logic [9:0] addr, input int len, input int pat);
        int k = 0;
        clear_trk();
        rd_track = 1'b1; iss_next = addr; iss_target = len + 1;
        rd_ready = 1'b1;
        do_cmd(1'b0, addr, len);
        while ((rd_q.size() < len + 1 || busy) && k < TMO) begin
            rd_ready = (pat == 0) ? 1'b1 : ((k % 3) == 0);
            @(posedge clk); #1; k++;
        end
        if (k >= TMO) chk("read_timeout", 1, 0);
        rd_ready = 1'b0;
        rd_track = 1'b0;
    endtask

    task automatic check_read(input logic [9:0] addr, input int len);
        chk("rd_beats", rd_q.size(), len + 1);
        for (int i = 0; i <= len && i < rd_q.size(); i++) begin
            chk("rd_data", {24'd0, rd_q[i][7:0]}, {24'd0, ref_mem[(int'(addr) + i) % 1024]});
            chk("rd_last", {31'd0, rd_q[i][8]}, (i == len) ? 1 : 0);
        end
        chk("rd_issue_seq", iss_cnt, len + 1);
        chk("rd_credit", credit_bad, 0);
    endtask

    initial begin : main
        logic [9:0] a;
        int         l;
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        clear_trk();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single beat write then single beat read with latency check.
        wbuf[0] = 8'h56;
        do_write(10'd55, 0, 1'b0);
        check_write(10'd55, 0);
        do_read(10'd55, 0, 0);
        check_read(10'd55, 0);
        chk("rd_latency", first_rdv_cyc - first_iss_cyc, RD_LAT + 1);
        chk("busy_back_low", busy, 0);
        chk("idle_addr_hold", ram_addr, 55);
        chk("idle_we_low", ram_we, 0);

        // Wrapping write across the top of memory and read back.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'h10 + 8'(i);
        do_write(10'd1022, 3, 1'b0);
        check_write(10'd1022, 3);
        chk("ram_1022", ram_mem[1022], 8'h10);
        chk("ram_1023", ram_mem[1023], 8'h11);
        chk("ram_0", ram_mem[0], 8'h12);
        chk("ram_1", ram_mem[1], 8'h13);
        chk("idle_addr_hold_wrap", ram_addr, 1);
        do_read(10'd1022, 3, 0);
        check_read(10'd1022, 3);

        // Eight beat read under heavy backpressure.
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(10'd300, 7, 1'b0);
        do_read(10'd300, 7, 1);
        check_read(10'd300, 7);

        // Gapped write: ram_we only on handshakes, cmd_ready returns the cycle after.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(10'd500, 3, 1'b1);
        check_write(10'd500, 3);
        chk("cmd_ready_return", cmdrdy_rise_cyc, last_we_cyc + 1);

        // Reset in the middle of a six beat read.
        wbuf[0] = 8'hA5;
        do_write(10'd66, 0, 1'b0);
        for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
        do_write(10'd200, 5, 1'b0);
        begin : mid_reset
            int k = 0;
            clear_trk();
            rd_track = 1'b1; iss_next = 10'd200; iss_target = 6;
            rd_ready = 1'b1;
            do_cmd(1'b0, 10'd200, 5);
            while (rd_q.size() < 2 && k < TMO) begin @(posedge clk); #1; k++; end
            if (k >= TMO) chk("mid_reset_timeout", 1, 0);
            rst = 1'b1;
            #1;
            chk("mrst_rd_valid", rd_valid, 0);
            chk("mrst_ram_we", ram_we, 0);
            chk("mrst_busy", busy, 0);
            chk("mrst_beat0", {23'd0, rd_q[0]}, {23'd0, 1'b0, ref_mem[200]});
            chk("mrst_beat1", {23'd0, rd_q[1]}, {23'd0, 1'b0, ref_mem[201]});
            rd_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end
        do_read(10'd66, 0, 0);
        check_read(10'd66, 0);
        chk("post_reset_value", {24'd0, rd_q[0][7:0]}, 32'hA5);

        // Burst crossing the top address.
        for (int i = 0; i < 6; i++) wbuf[i] = 8'h80 + 8'(i);
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
        clear_trk();
        wr_valid = 1'b1; wr_data = 8'hEE;
        do_cmd(1'b1, 10'd1020, 5);
        repeat (6) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        chk("err_pulse_cycles", err_cycles, 1);
        chk("err_no_we", wr_log.size(), 0);
        chk("err_busy_never", busy_cycles, 0);
        chk("err_no_wr_ready", wrrdy_cycles, 0);
`else
        do_write(10'd1020, 5, 1'b0);
        check_write(10'd1020, 5);
        do_read(10'd1020, 5, 0);
        check_read(10'd1020, 5);
`endif

        // Randomized bursts checked against the reference image.
        for (int t = 0; t < 16; t++) begin
            a = 10'($urandom);
            l = $urandom_range(0, 15);
`ifdef RAM_BURST_CTRL_BOUNDARY_ERR_EN
            if (int'(a) + l > 1023) a = 10'(1023 - l);
`endif
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= l; i++) wbuf[i] = 8'($urandom);
                do_write(a, l, 1'($urandom_range(0, 1)));
                check_write(a, l);
            end else begin
                do_read(a, l, $urandom_range(0, 1));
                check_read(a, l);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Host-side access controller that sits directly upstream of the single-port 1K x 8 synchronous RAM and drives its write_enable/address/data_in ports.
- Accepts burst commands over valid/ready handshakes.
- Sequences auto-incrementing RAM accesses.
- Returns read data with backpressure through a small credit-managed output FIFO.
- Lets multiple producers and consumers share the RAM without per-cycle pin control.

Parameters:
ADDR_W, 10, RAM address width (1024 locations)
DATA_W, 8, RAM data width
LEN_W, 8, burst length field width; burst beats = cmd_len + 1 (1..256)
RD_LAT, 1, RAM read latency in clocks from address to valid data_out (1..3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  LEN_W  beats minus one
wr_valid  input  1  write beat present
wr_ready  output  1  write beat accepted
wr_data  input  DATA_W  write beat data
rd_valid  output  1  read beat present
rd_ready  input  1  consumer accepts read beat
rd_data  output  DATA_W  read beat data
rd_last  output  1  final beat of the read burst
busy  output  1  state != IDLE
ram_we  output  1  to RAM write_enable
ram_addr  output  ADDR_W  to RAM address
ram_wdata  output  DATA_W  to RAM data_in
ram_rdata  input  DATA_W  from RAM data_out

Behaviour:
- Reset (async assert, sync release) forces the following; read FIFO is emptied and in-flight reads are discarded.
  - state = IDLE
  - cmd_ready = 1, wr_ready = 0, rd_valid = 0, rd_last = 0, rd_data = 0
  - ram_we = 0, ram_addr = 0, ram_wdata = 0, busy = 0
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch addr, remaining = cmd_len, and lastflag source.
  - Go to WRITE if cmd_write, else READ.
  - cmd_ready = 0 in all other states.
- WRITE:
  - wr_ready = 1.
  - Each accepted beat drives ram_we = 1, ram_addr = cur_addr, ram_wdata = wr_data in the SAME cycle (combinational from the handshake); the RAM captures it on the next edge.
  - cur_addr increments after each beat.
  - After the beat with remaining == 0, go to IDLE; the next command can be accepted on the following cycle.
  - wr_valid low inserts idle cycles with ram_we = 0.
- READ:
  - Each cycle, issue a read (ram_addr = cur_addr, ram_we = 0) only when inflight + fifo_count < FIFO_DEPTH (FIFO_DEPTH = RD_LAT + 2).
  - Tag each issued read with a last bit that is 1 on the remaining == 0 beat.
  - After issuing the last read, go to DRAIN.
- Read return:
  - A shift pipe of RD_LAT stages tracks valid/last.
  - At pipe exit, push {ram_rdata, last} into the FIFO.
  - rd_valid = FIFO not empty; rd_data/rd_last = FIFO head; pop on rd_valid && rd_ready.
  - Minimum latency from issue to rd_valid = RD_LAT + 1 cycles.
  - With rd_ready held high, throughput is 1 beat/cycle.
- DRAIN:
  - Issue nothing.
  - Return to IDLE when inflight == 0 and the FIFO is empty (the last beat has been popped).
- Address arithmetic:
  - cur_addr is ADDR_W bits; 1023 + 1 wraps to 0 (modulo 2^ADDR_W).
  - remaining decrements by 1 per issued beat and never underflows; the state exits at 0.
- rd_ready low: the FIFO fills and read issue stalls via credits. No beat is lost or duplicated, and the RAM address sequence holds.
- Between accesses (no write/read issued), ram_addr keeps its last value and ram_we = 0.
- Reset mid-burst: the burst is abandoned with no further RAM writes. The host must reissue.

Optional Feature:
RAM_BURST_CTRL_BOUNDARY_ERR_EN
- When defined:
  - Adds output port cmd_err (1 bit, reset 0).
  - A command with cmd_addr + cmd_len > 2^ADDR_W - 1 is still handshaken but is rejected: cmd_err pulses high for exactly one cycle after acceptance.
  - State remains IDLE; no RAM access occurs, no wr beats are consumed, no rd beats are produced.
- When undefined:
  - No cmd_err port.
  - Crossing bursts wrap silently to address 0.

Decomposition:
- Shared package ram_pkg:
  - ADDR_W/DATA_W defaults
  - FSM state enum (IDLE, WRITE, READ, DRAIN; 2-bit encoding)
  - read-beat struct {data, last}
- One sub-module: ram_rd_fifo.
  - Synchronous FIFO, depth FIFO_DEPTH, width DATA_W + 1.
  - Outputs: count, empty, full.
  - Resets to empty on rst.

Test Plan:
- Write 1 beat 0x56 to addr 55, then read len 0 at 55 (rd_ready = 1) -> rd_data = 0x56, rd_last = 1, rd_valid exactly RD_LAT + 1 cycles after issue; busy returns to 0.
- Write 4 beats 0x10..0x13 at addr 1022 -> RAM locations 1022, 1023, 0, 1 hold 0x10..0x13. Read back -> same order, rd_last only on 0x13.
- Read 8 beats with rd_ready toggling 1 cycle high / 2 low -> all 8 values in address order, none dropped or repeated; inflight + fifo_count never exceeds FIFO_DEPTH.
- Write burst len 3 with wr_valid gapped (beat, idle, beat, idle...) -> ram_we high only on handshake cycles, addresses consecutive, and cmd_ready is first seen high again in the cycle after the 4th beat.
- Assert rst after 2 of 6 read beats -> rd_valid, ram_we and busy go 0 immediately. After release, a new read len 0 at addr 66 returns the single correct value.
- With RAM_BURST_CTRL_BOUNDARY_ERR_EN: cmd addr 1020, len 5 -> cmd_err high for 1 cycle, ram_we never asserted, busy stays 0. Without the macro: the same command writes 1020..1023 and 0..1.
